// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default field layout for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_OPCODE_WIDTH = 3;
  localparam int unsigned IFU_ADDR_WIDTH   = 5;
  localparam int unsigned IFU_DATA_WIDTH   = IFU_OPCODE_WIDTH + IFU_ADDR_WIDTH;
  localparam int unsigned OPCODE_LSB       = IFU_ADDR_WIDTH;
  localparam int unsigned OPCODE_MSB       = IFU_DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FULL  = 2'd2,
    ST_FLUSH = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ack read port; master side is the fetch unit.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = instr_fetch_unit_pkg::IFU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = instr_fetch_unit_pkg::IFU_DATA_WIDTH
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (output mem_req, output mem_addr, input  mem_rdata, input  mem_ack);
  modport slave  (input  mem_req, input  mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter plus one-word prefetch buffer feeding the control unit's
// fetch strobe from a req/ack instruction memory; handles jumps and flushes.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = IFU_OPCODE_WIDTH,
  parameter int unsigned ADDR_WIDTH   = IFU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = OPCODE_WIDTH + ADDR_WIDTH,
  parameter int unsigned RESET_PC     = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    fetch,
  input  logic                    pc_load,
  input  logic [ADDR_WIDTH-1:0]   pc_load_addr,
  instr_fetch_unit_if.master      mem,
  output logic [OPCODE_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]   operand,
  output logic                    instr_valid,
  output logic                    stall,
  output logic [ADDR_WIDTH-1:0]   pc
);

  localparam int unsigned OpLsb = ADDR_WIDTH;
  localparam int unsigned OpMsb = DATA_WIDTH - 1;

  ifu_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                    buf_vld_q, buf_vld_d;
  logic                    pend_q, pend_d;
  logic                    fetch_q;
  logic [OPCODE_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   operand_q, operand_d;
  logic                    instr_vld_q, instr_vld_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    fetch_rise;
  logic                    consume;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      pc_q        <= ADDR_WIDTH'(RESET_PC);
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      pend_q      <= 1'b0;
      fetch_q     <= 1'b1;
      instr_q     <= '0;
      operand_q   <= '0;
      instr_vld_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= ADDR_WIDTH'(RESET_PC);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      pend_q      <= pend_d;
      fetch_q     <= fetch;
      instr_q     <= instr_d;
      operand_q   <= operand_d;
      instr_vld_q <= instr_vld_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    pend_d      = pend_q;
    instr_d     = instr_q;
    operand_d   = operand_q;
    instr_vld_d = instr_vld_q;
    fetch_rise  = fetch & ~fetch_q;
    consume     = fetch_rise | pend_q;

    if (pc_load) begin
      pc_d      = pc_load_addr;
      buf_vld_d = 1'b0;
      pend_d    = pend_q | fetch_rise;
      // An ack arriving with the jump retires the old request, so no flush wait is needed.
      case (state_q)
        ST_REQ, ST_FLUSH: state_d = mem.mem_ack ? ST_REQ : ST_FLUSH;
        default:          state_d = ST_REQ;
      endcase
    end else begin
      if (fetch_rise && !buf_vld_q) begin
        pend_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (!buf_vld_q) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (mem.mem_ack) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
            if (consume) begin
              instr_d     = mem.mem_rdata[OpMsb:OpLsb];
              operand_d   = mem.mem_rdata[ADDR_WIDTH-1:0];
              instr_vld_d = 1'b1;
              pend_d      = 1'b0;
            end else begin
              buf_d     = mem.mem_rdata;
              buf_vld_d = 1'b1;
              state_d   = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (consume) begin
            instr_d     = buf_q[OpMsb:OpLsb];
            operand_d   = buf_q[ADDR_WIDTH-1:0];
            instr_vld_d = 1'b1;
            pend_d      = 1'b0;
            buf_vld_d   = 1'b0;
            state_d     = ST_REQ;
          end
        end
        ST_FLUSH: begin
          if (mem.mem_ack) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Address only moves when a fresh request starts; it holds through FLUSH.
    mem_req_d  = (state_d == ST_REQ) || (state_d == ST_FLUSH);
    mem_addr_d = (state_d == ST_REQ) ? pc_d : mem_addr_q;
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign instr        = instr_q;
  assign operand      = operand_q;
  assign instr_valid  = instr_vld_q;
  assign stall        = pend_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hit, miss/bypass, flush, wrap, jump-on-ack, reset.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          CLK;
  logic          RST;
  logic          fetch;
  logic          pc_load;
  logic [AW-1:0] pc_load_addr;
  logic [2:0]    instr;
  logic [AW-1:0] operand;
  logic          instr_valid;
  logic          stall;
  logic [AW-1:0] pc;

  int nvec;
  int nerr;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  instr_fetch_unit #(.OPCODE_WIDTH(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(0)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .fetch        (fetch),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .mem          (mem.master),
    .instr        (instr),
    .operand      (operand),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .pc           (pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"},      32'(pc),          32'd0);
    chk({tag, "_instr"},   32'(instr),       32'd0);
    chk({tag, "_operand"}, 32'(operand),     32'd0);
    chk({tag, "_valid"},   32'(instr_valid), 32'd0);
    chk({tag, "_stall"},   32'(stall),       32'd0);
    chk({tag, "_req"},     32'(mem.mem_req), 32'd0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    RST = 1'b1;
    fetch = 1'b0;
    pc_load = 1'b0;
    pc_load_addr = '0;
    mem.mem_ack = 1'b0;
    mem.mem_rdata = '0;
    tick();
    tick();
    chk_reset_outputs("rst");

    // Prefetch hit
    RST = 1'b0;
    tick();
    chk("first_req", 32'(mem.mem_req), 32'd1);
    chk("first_addr", 32'(mem.mem_addr), 32'd0);
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'b001_00101;
    tick();
    mem.mem_ack = 1'b0;
    chk("full_pc", 32'(pc), 32'd1);
    chk("full_req", 32'(mem.mem_req), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd0);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("hit_instr", 32'(instr), 32'd1);
    chk("hit_operand", 32'(operand), 32'd5);
    chk("hit_valid", 32'(instr_valid), 32'd1);
    chk("hit_req", 32'(mem.mem_req), 32'd1);
    chk("hit_addr", 32'(mem.mem_addr), 32'd1);

    // Miss with delayed ack, bypass delivery
    tick();
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("miss_stall0", 32'(stall), 32'd1);
    chk("miss_old_instr", 32'(instr), 32'd1);
    tick();
    chk("miss_stall1", 32'(stall), 32'd1);
    tick();
    chk("miss_stall2", 32'(stall), 32'd1);
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'b010_00111;
    tick();
    mem.mem_ack = 1'b0;
    chk("byp_instr", 32'(instr), 32'd2);
    chk("byp_operand", 32'(operand), 32'd7);
    chk("byp_stall", 32'(stall), 32'd0);
    chk("byp_pc", 32'(pc), 32'd2);
    chk("byp_req", 32'(mem.mem_req), 32'd1);
    chk("byp_addr", 32'(mem.mem_addr), 32'd2);

    // Jump while request to addr 2 is outstanding
    pc_load = 1'b1; pc_load_addr = 5'd20;
    tick();
    pc_load = 1'b0;
    chk("flush_pc", 32'(pc), 32'd20);
    chk("flush_req", 32'(mem.mem_req), 32'd1);
    chk("flush_addr_hold", 32'(mem.mem_addr), 32'd2);
    tick();
    chk("flush_req_hold", 32'(mem.mem_req), 32'd1);
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'b111_11111;
    tick();
    mem.mem_ack = 1'b0;
    chk("flush_new_addr", 32'(mem.mem_addr), 32'd20);
    chk("flush_new_req", 32'(mem.mem_req), 32'd1);
    chk("flush_drop_instr", 32'(instr), 32'd2);
    chk("flush_drop_pc", 32'(pc), 32'd20);
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'b011_00001;
    tick();
    mem.mem_ack = 1'b0;
    chk("t20_pc", 32'(pc), 32'd21);
    chk("t20_req", 32'(mem.mem_req), 32'd0);

    // Jump to 31 from FULL, then wrap
    pc_load = 1'b1; pc_load_addr = 5'd31;
    tick();
    pc_load = 1'b0;
    chk("j31_addr", 32'(mem.mem_addr), 32'd31);
    chk("j31_req", 32'(mem.mem_req), 32'd1);
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'b100_00011;
    tick();
    mem.mem_ack = 1'b0;
    chk("wrap_pc", 32'(pc), 32'd0);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("wrap_instr", 32'(instr), 32'd4);
    chk("wrap_operand", 32'(operand), 32'd3);
    chk("wrap_addr", 32'(mem.mem_addr), 32'd0);

    // Jump coinciding with ack: data dropped, buffer stays empty
    pc_load = 1'b1; pc_load_addr = 5'd10;
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'b101_01010;
    tick();
    pc_load = 1'b0;
    mem.mem_ack = 1'b0;
    chk("jack_pc", 32'(pc), 32'd10);
    chk("jack_addr", 32'(mem.mem_addr), 32'd10);
    chk("jack_instr", 32'(instr), 32'd4);
    fetch = 1'b1;
    tick();
    chk("jack_empty_stall", 32'(stall), 32'd1);

    // Reset mid-request with a pending fetch, stray ack afterwards
    RST = 1'b1;
    tick();
    chk_reset_outputs("mrst");
    RST = 1'b0;
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'b110_00110;
    tick();
    mem.mem_ack = 1'b0;
    chk("stray_pc", 32'(pc), 32'd0);
    chk("stray_req", 32'(mem.mem_req), 32'd1);
    chk("stray_addr", 32'(mem.mem_addr), 32'd0);
    chk("stray_no_edge", 32'(stall), 32'd0);
    tick();
    chk("stray_pc2", 32'(pc), 32'd0);
    chk("stray_req2", 32'(mem.mem_req), 32'd1);
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'b110_00110;
    tick();
    mem.mem_ack = 1'b0;
    fetch = 1'b0;
    chk("post_pc", 32'(pc), 32'd1);
    tick();
    fetch = 1'b1;
    tick();
    chk("post_instr", 32'(instr), 32'd6);
    chk("post_operand", 32'(operand), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
